// File: rtl/nn_pkg.sv
// Shared types for the neuron layer: driver FSM states and neuron activation selection.
package nn_pkg;

  typedef enum logic [1:0] {
    LOADING  = 2'd0,
    STARTING = 2'd1,
    WAITING  = 2'd2,
    DRAINING = 2'd3
  } driver_state;

  typedef enum logic [1:0] {
    ACT_LINEAR  = 2'd0,
    ACT_RELU    = 2'd1,
    ACT_SIGMOID = 2'd2,
    ACT_TANH    = 2'd3
  } activation_type;

endpackage

// File: rtl/neuron_driver_if.sv
// Stream and neuron-bank signals of one neuron_driver; master is the driver side.
interface neuron_driver_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_INPUTS  = 16,
  parameter int NUM_NEURONS = 4
);

  logic signed [DATA_WIDTH-1:0] in_data;
  logic                         in_valid;
  logic                         in_ready;

  logic signed [DATA_WIDTH-1:0] neuron_inputs [NUM_INPUTS];
  logic                         neuron_input_ready;
  logic signed [DATA_WIDTH-1:0] neuron_outputs [NUM_NEURONS];
  logic [NUM_NEURONS-1:0]       neuron_output_ready;

  logic signed [DATA_WIDTH-1:0] out_data;
  logic                         out_valid;
  logic                         out_ready;

  modport master (
    input  in_data, in_valid,
    output in_ready,
    output neuron_inputs, neuron_input_ready,
    input  neuron_outputs, neuron_output_ready,
    output out_data, out_valid,
    input  out_ready
  );

  modport slave (
    output in_data, in_valid,
    input  in_ready,
    input  neuron_inputs, neuron_input_ready,
    output neuron_outputs, neuron_output_ready,
    input  out_data, out_valid,
    output out_ready
  );

endinterface

// File: rtl/neuron_driver_input_deserializer.sv
// Collects NUM_INPUTS stream words into a parallel vector; flags the cycle the last word lands.
module input_deserializer #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_INPUTS = 16
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  input  logic                         wr_en,
  output logic signed [DATA_WIDTH-1:0] buffer [NUM_INPUTS],
  output logic                         last_word
);

  localparam int              CW       = $clog2(NUM_INPUTS);
  localparam logic [CW-1:0]   LAST_IDX = CW'(NUM_INPUTS - 1);

  logic [CW-1:0] load_count;

  assign last_word = wr_en && (load_count == LAST_IDX);

  // NOTE: the vector is small and drives the neurons directly, so every word is
  // reset to keep the neurons from ever seeing X after reset or an abort.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      load_count <= '0;
      for (int i = 0; i < NUM_INPUTS; i++) buffer[i] <= '0;
    end else if (wr_en) begin
      // NOTE: non-blocking so every flop samples pre-edge values regardless of statement order.
      buffer[load_count] <= in_data;
      load_count         <= last_word ? '0 : load_count + 1'b1;
    end
  end

endmodule

// File: rtl/neuron_driver.sv
// Feeds one input vector to a neuron bank, collects each neuron's result and streams them out.
module neuron_driver
  import nn_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_INPUTS     = 16,
  parameter int NUM_NEURONS    = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic            clock,
  input  logic            reset,
  neuron_driver_if.master bus,
  output logic            timeout_error,
  output logic            protocol_error
);

  localparam int            DW_IDX = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
  localparam int            TW     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [DW_IDX-1:0] D_LAST = DW_IDX'(NUM_NEURONS - 1);
  localparam logic [TW-1:0]     T_MAX  = TW'(TIMEOUT_CYCLES - 1);

  driver_state                  state;
  logic                         run_q;
  logic                         start_q;
  logic [NUM_NEURONS-1:0]       captured;
  logic [NUM_NEURONS-1:0]       captured_d;
  logic signed [DATA_WIDTH-1:0] results   [NUM_NEURONS];
  logic signed [DATA_WIDTH-1:0] results_d [NUM_NEURONS];
  logic [TW-1:0]                timeout_cnt;
  logic [DW_IDX-1:0]            drain_idx;
  logic signed [DATA_WIDTH-1:0] out_data_q;
  logic signed [DATA_WIDTH-1:0] buffer [NUM_INPUTS];
  logic                         wr_en;
  logic                         last_word;
  logic                         all_done;

  // run_q keeps in_ready low while reset is held even though state already reads LOADING.
  assign bus.in_ready           = (state == LOADING) && run_q;
  assign bus.out_valid          = (state == DRAINING);
  assign bus.out_data           = out_data_q;
  assign bus.neuron_input_ready = start_q;
  assign bus.neuron_inputs      = buffer;

  assign wr_en = bus.in_valid && bus.in_ready;

  input_deserializer #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_INPUTS (NUM_INPUTS)
  ) u_deser (
    .clock     (clock),
    .reset     (reset),
    .in_data   (bus.in_data),
    .wr_en     (wr_en),
    .buffer    (buffer),
    .last_word (last_word)
  );

  // Results as they would be after this cycle's pulses, so completion sees same-cycle captures.
  always_comb begin
    // NOTE: every output of a combinational block is assigned on all paths to avoid latches.
    captured_d = captured | bus.neuron_output_ready;
    for (int i = 0; i < NUM_NEURONS; i++)
      results_d[i] = bus.neuron_output_ready[i] ? bus.neuron_outputs[i] : results[i];
  end

  assign all_done = &captured_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= LOADING;
      run_q          <= 1'b0;
      start_q        <= 1'b0;
      captured       <= '0;
      timeout_cnt    <= '0;
      drain_idx      <= '0;
      out_data_q     <= '0;
      timeout_error  <= 1'b0;
      protocol_error <= 1'b0;
      for (int i = 0; i < NUM_NEURONS; i++) results[i] <= '0;
    end else begin
      run_q   <= 1'b1;
      start_q <= last_word;

      if (state != WAITING && |bus.neuron_output_ready)
        protocol_error <= 1'b1;

      case (state)
        LOADING: begin
          if (last_word) state <= STARTING;
        end

        STARTING: begin
          captured    <= '0;
          timeout_cnt <= '0;
          for (int i = 0; i < NUM_NEURONS; i++) results[i] <= '0;
          state <= WAITING;
        end

        WAITING: begin
          captured <= captured_d;
          results  <= results_d;
          if (all_done) begin
            out_data_q <= results_d[0];
            drain_idx  <= '0;
            state      <= DRAINING;
          end else if (timeout_cnt == T_MAX) begin
            timeout_error <= 1'b1;
            out_data_q    <= results_d[0];
            drain_idx     <= '0;
            state         <= DRAINING;
          end else begin
            timeout_cnt <= timeout_cnt + 1'b1;
          end
        end

        DRAINING: begin
          if (bus.out_ready) begin
            if (drain_idx == D_LAST) begin
              drain_idx  <= '0;
              out_data_q <= '0;
              state      <= LOADING;
            end else begin
              drain_idx  <= drain_idx + 1'b1;
              out_data_q <= results[drain_idx + 1'b1];
            end
          end
        end

        default: state <= LOADING;
      endcase
    end
  end

endmodule

// File: doc/neuron_driver.md
Name: neuron_driver

Overview:
Upstream feeder and downstream collector for a bank of neurons that share one input vector.
- Deserialises a valid/ready word stream into the parallel `inputs` vector and pulses `input_ready` to the neurons.
- Captures each neuron's `out` on its `output_ready` pulse, then serialises the results back onto a valid/ready output stream.
- Sits between the layer-to-layer stream fabric and the neuron instances of one layer.

Parameters:
- DATA_WIDTH, 32, width of every data word (signed).
- NUM_INPUTS, 16, words per input vector; must be >= 2.
- NUM_NEURONS, 4, neurons driven and collected; must be >= 1.
- TIMEOUT_CYCLES, 1024, maximum cycles spent in WAITING before abort.

Ports:
- clock, input, 1, single clock; all flops on rising edge.
- reset, input, 1, asynchronous active-low reset.
- in_data, input, DATA_WIDTH signed, stream input word.
- in_valid, input, 1, in_data valid.
- in_ready, output, 1, driver accepts in_data this cycle.
- neuron_inputs, output, DATA_WIDTH signed x NUM_INPUTS, parallel vector to the neurons.
- neuron_input_ready, output, 1, one-cycle start pulse to the neurons.
- neuron_outputs, input, DATA_WIDTH signed x NUM_NEURONS, neuron results.
- neuron_output_ready, input, NUM_NEURONS, per-neuron done pulses.
- out_data, output, DATA_WIDTH signed, stream output word.
- out_valid, output, 1, out_data valid.
- out_ready, input, 1, downstream accepts out_data.
- timeout_error, output, 1, sticky; set on WAITING timeout.
- protocol_error, output, 1, sticky; set on an output_ready pulse outside WAITING.

Behaviour:
- Reset (reset low, asynchronous) clears all state:
  - state = LOADING; buffer, counters, results and captured flags = 0.
  - in_ready=0, neuron_input_ready=0, out_valid=0, out_data=0, both error flags = 0.
  - The first cycle after release asserts in_ready=1.
- Reset mid-operation aborts immediately. Partial vectors and results are discarded; no output pulse is emitted.
- Only reset clears the sticky error flags.
- LOADING:
  - in_ready=1.
  - On in_valid&&in_ready: buffer[load_count] <= in_data; load_count++.
  - When the word at index NUM_INPUTS-1 is accepted: load_count <= 0, go to STARTING.
- STARTING:
  - neuron_input_ready=1 for exactly this cycle; in_ready=0.
  - Clear all captured flags and the timeout counter; go to WAITING.
- WAITING:
  - in_ready=0. neuron_inputs is held stable from STARTING until the state returns to LOADING, because neurons sample inputs one cycle after the start pulse.
  - Each cycle, for every i with neuron_output_ready[i]=1: results[i] <= neuron_outputs[i]; captured[i] <= 1.
  - Multiple simultaneous pulses are all captured in the same cycle.
  - A repeat pulse on an already-captured neuron overwrites its result; no error.
  - When all flags are set, counting pulses arriving this cycle: go to DRAINING next cycle.
  - The timeout counter increments every WAITING cycle. If it reaches TIMEOUT_CYCLES-1 without completion: timeout_error <= 1, go to DRAINING. Uncaptured results drain as 0.
- DRAINING:
  - out_valid=1; out_data = results[drain_idx].
  - out_data is held stable while out_valid&&!out_ready.
  - On out_ready: drain_idx++. After index NUM_NEURONS-1 is accepted: drain_idx <= 0, out_valid <= 0, go to LOADING.
  - Back-to-back: the next cycle is LOADING with in_ready=1.
- Any neuron_output_ready bit high in LOADING, STARTING or DRAINING is ignored for data and sets protocol_error.
- Latency:
  - Last input word accepted -> neuron_input_ready: 1 cycle.
  - Final capture -> first out_valid: 1 cycle.
- Widths: no arithmetic on data; words pass through bit-exact and signed. Counters are sized $clog2 of their range. The timeout counter saturates.
- Outputs are registered except in_ready and out_valid, which decode directly from the state register.

Decomposition:
- Shared package nn_pkg holds:
  - The driver_state enum (LOADING, STARTING, WAITING, DRAINING).
  - The existing activation_type typedef, moved alongside.
- One sub-module, input_deserializer: buffer array, load_count, write enable and a last-word flag. It is instanced once; the FSM, collector and drain logic stay in neuron_driver.

Test Plan (bench uses NUM_INPUTS=4, NUM_NEURONS=2, TIMEOUT_CYCLES=16):
- Stream 1,2,3,4 with no gaps -> neuron_input_ready pulses 1 cycle after word 4; neuron_inputs={1,2,3,4} is held stable. Pulse outputs 10 then -7 on separate cycles -> out stream 10,-7; in_ready returns next cycle.
- in_valid toggled every other cycle during load, and out_ready low for 3 cycles during drain -> same vectors as above; out_data holds 10 during the stall; no words lost or duplicated.
- Both output_ready bits pulsed in the same cycle with 5 and 6 -> DRAINING next cycle; stream 5,6.
- Only neuron 0 responds (value 9) -> timeout_error=1 after 16 WAITING cycles; stream 9,0; next vector is accepted normally with the flag still set.
- output_ready[1] pulsed during LOADING -> protocol_error=1; buffer contents unaffected.
- reset driven low during DRAINING after the first word -> all outputs 0 immediately; after release, in_ready=1 and a fresh 4-word vector completes correctly.
